// File: rtl/display_pkg.sv
// Shared raster timing definitions: coordinate type and standard video mode timing sets.
package display_pkg;
  localparam int COORD_W = 16;
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    int   res;
    int   fp;
    int   sync;
    int   bp;
    logic pol;
  } axis_timing_t;

  localparam axis_timing_t T480P60_H  = '{res: 640,  fp: 16,  sync: 96, bp: 48,  pol: 1'b0};
  localparam axis_timing_t T480P60_V  = '{res: 480,  fp: 10,  sync: 2,  bp: 33,  pol: 1'b0};
  localparam axis_timing_t T720P60_H  = '{res: 1280, fp: 110, sync: 40, bp: 220, pol: 1'b1};
  localparam axis_timing_t T720P60_V  = '{res: 720,  fp: 5,   sync: 5,  bp: 20,  pol: 1'b1};
  localparam axis_timing_t T1080P60_H = '{res: 1920, fp: 88,  sync: 44, bp: 148, pol: 1'b1};
  localparam axis_timing_t T1080P60_V = '{res: 1080, fp: 4,   sync: 5,  bp: 36,  pol: 1'b1};

  // Blanking lives at negative coordinates, so an axis starts at minus its blanking length.
  function automatic int axis_start(input int fp, input int sync, input int bp);
    return -(fp + sync + bp);
  endfunction
endpackage

// File: rtl/display_axis_counter.sv
// One raster axis: counts STA..END and wraps, exposing the next value for zero-skew flag decode.
module display_axis_counter
  import display_pkg::*;
#(
  parameter int STA = -370,
  parameter int END = 1279
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t pos,
  output coord_t pos_next,
  output logic   wrap
);
  localparam coord_t STA_C = coord_t'(STA);
  localparam coord_t END_C = coord_t'(END);

  always_comb begin
    wrap     = en && (pos == END_C);
    pos_next = pos;
    if (en) begin
      pos_next = (pos == END_C) ? STA_C : pos + coord_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= END_C;
    end else begin
      pos <= pos_next;
    end
  end
endmodule

// File: rtl/display_timings.sv
// Free-running raster timing generator with signed coordinates and registered, zero-skew flags.
module display_timings
  import display_pkg::*;
#(
  parameter int H_RES  = T720P60_H.res,
  parameter int H_FP   = T720P60_H.fp,
  parameter int H_SYNC = T720P60_H.sync,
  parameter int H_BP   = T720P60_H.bp,
  parameter int V_RES  = T720P60_V.res,
  parameter int V_FP   = T720P60_V.fp,
  parameter int V_SYNC = T720P60_V.sync,
  parameter int V_BP   = T720P60_V.bp,
  parameter bit H_POL  = T720P60_H.pol,
  parameter bit V_POL  = T720P60_V.pol
) (
  input  logic                      i_pix_clk,
  input  logic                      i_rst,
  output logic                      o_hs,
  output logic                      o_vs,
  output logic                      o_de,
  output logic                      o_frame,
  output logic                      o_line,
  output logic signed [COORD_W-1:0] o_sx,
  output logic signed [COORD_W-1:0] o_sy
);
  localparam int H_STA = axis_start(H_FP, H_SYNC, H_BP);
  localparam int H_END = H_RES - 1;
  localparam int V_STA = axis_start(V_FP, V_SYNC, V_BP);
  localparam int V_END = V_RES - 1;

  localparam coord_t HS_BEG_C = coord_t'(H_STA + H_FP);
  localparam coord_t HS_END_C = coord_t'(H_STA + H_FP + H_SYNC);
  localparam coord_t VS_BEG_C = coord_t'(V_STA + V_FP);
  localparam coord_t VS_END_C = coord_t'(V_STA + V_FP + V_SYNC);

  if (H_STA < -32768 || V_STA < -32768 || H_END > 32767 || V_END > 32767) begin : g_width_check
    $error("display_timings: timing does not fit signed 16-bit coordinates");
  end

  coord_t sx_next, sy_next;
  logic   h_wrap, v_wrap;
  logic   hs_p0, vs_p0, de_p0;

  display_axis_counter #(.STA(H_STA), .END(H_END)) u_h_axis (
    .clk      (i_pix_clk),
    .rst      (i_rst),
    .en       (1'b1),
    .pos      (o_sx),
    .pos_next (sx_next),
    .wrap     (h_wrap)
  );

  display_axis_counter #(.STA(V_STA), .END(V_END)) u_v_axis (
    .clk      (i_pix_clk),
    .rst      (i_rst),
    .en       (h_wrap),
    .pos      (o_sy),
    .pos_next (sy_next),
    .wrap     (v_wrap)
  );

  // Decode flags from the next coordinates so they register alongside them.
  always_comb begin
    hs_p0 = (sx_next >= HS_BEG_C) && (sx_next < HS_END_C);
    vs_p0 = (sy_next >= VS_BEG_C) && (sy_next < VS_END_C);
    de_p0 = (sx_next >= coord_t'(0)) && (sy_next >= coord_t'(0));
  end

  // A horizontal wrap lands on H_STA (line start); a vertical wrap implies both (frame start).
  always_ff @(posedge i_pix_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hs    <= !H_POL;
      o_vs    <= !V_POL;
      o_de    <= 1'b0;
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end else begin
      o_hs    <= hs_p0 ? H_POL : !H_POL;
      o_vs    <= vs_p0 ? V_POL : !V_POL;
      o_de    <= de_p0;
      o_line  <= h_wrap;
      o_frame <= v_wrap;
    end
  end
endmodule

// File: tb/tb_display_timings.sv
// Directed bench for display_timings: 720p defaults, 640x480 negative polarity, and a tiny raster for frame-level checks.
module tb_display_timings;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

  logic hs_a, vs_a, de_a, frame_a, line_a;
  logic signed [15:0] sx_a, sy_a;
  logic hs_b, vs_b, de_b, frame_b, line_b;
  logic signed [15:0] sx_b, sy_b;
  logic hs_c, vs_c, de_c, frame_c, line_c;
  logic signed [15:0] sx_c, sy_c;

  display_timings dut_a (
    .i_pix_clk(clk), .i_rst(rst_a), .o_hs(hs_a), .o_vs(vs_a), .o_de(de_a),
    .o_frame(frame_a), .o_line(line_a), .o_sx(sx_a), .o_sy(sy_a)
  );

  display_timings #(
    .H_RES(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_RES(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_b (
    .i_pix_clk(clk), .i_rst(rst_b), .o_hs(hs_b), .o_vs(vs_b), .o_de(de_b),
    .o_frame(frame_b), .o_line(line_b), .o_sx(sx_b), .o_sy(sy_b)
  );

  display_timings #(
    .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_c (
    .i_pix_clk(clk), .i_rst(rst_c), .o_hs(hs_c), .o_vs(vs_c), .o_de(de_c),
    .o_frame(frame_c), .o_line(line_c), .o_sx(sx_c), .o_sy(sy_c)
  );

  typedef struct {
    string tag;
    int    exp;
  } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic expect_val(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_val(input int obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    expect_val(tag, exp);
    check_val(obs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, k, hs_cnt, hs_min, hs_max, de_cnt;
    int lines, period, vs_cnt, vs_min, vs_max;
    int frames, fperiod, wraps, w_sx, w_sy, w_fr, w_ln, w_de, end_de;
    logic prev_end;

    // Reset held: all three instances sit at reset values
    repeat (3) tick();
    chk("a_rst_sx", int'(sx_a), 1279);
    chk("a_rst_sy", int'(sy_a), 719);
    chk("a_rst_de", int'(de_a), 0);
    chk("a_rst_frame", int'(frame_a), 0);
    chk("a_rst_line", int'(line_a), 0);
    chk("a_rst_hs", int'(hs_a), 0);
    chk("a_rst_vs", int'(vs_a), 0);
    chk("b_rst_hs", int'(hs_b), 1);
    chk("b_rst_vs", int'(vs_b), 1);
    chk("c_rst_sx", int'(sx_c), 7);

    // Reset release on 720p instance
    #3 rst_a = 1'b0;
    tick();
    chk("a_rel_sx", int'(sx_a), -370);
    chk("a_rel_sy", int'(sy_a), -30);
    chk("a_rel_frame", int'(frame_a), 1);
    chk("a_rel_line", int'(line_a), 1);
    chk("a_rel_de", int'(de_a), 0);
    tick();
    chk("a_rel2_sx", int'(sx_a), -369);
    chk("a_rel2_frame", int'(frame_a), 0);
    chk("a_rel2_line", int'(line_a), 0);

    // One full 720p line
    expect_val("a_line_period", 1650);
    expect_val("a_hs_count", 40);
    expect_val("a_hs_first_x", -260);
    expect_val("a_hs_last_x", -221);
    expect_val("a_de_blank_line", 0);
    n = 1; hs_cnt = 0; hs_min = 32767; hs_max = -32768; de_cnt = 0;
    while (!line_a && n < 2000) begin
      if (hs_a) begin
        hs_cnt++;
        if (int'(sx_a) < hs_min) hs_min = int'(sx_a);
        if (int'(sx_a) > hs_max) hs_max = int'(sx_a);
      end
      if (de_a) de_cnt++;
      tick();
      n++;
    end
    check_val(n);
    check_val(hs_cnt);
    check_val(hs_min);
    check_val(hs_max);
    check_val(de_cnt);

    // Asynchronous reset mid-line
    k = 0;
    while (sx_a != 16'sd100 && k < 1000) begin
      tick();
      k++;
    end
    chk("a_reach_x100", int'(sx_a), 100);
    #2 rst_a = 1'b1;
    #1;
    chk("a_async_sx", int'(sx_a), 1279);
    chk("a_async_sy", int'(sy_a), 719);
    chk("a_async_de", int'(de_a), 0);
    chk("a_async_hs", int'(hs_a), 0);
    chk("a_async_line", int'(line_a), 0);
    tick();
    tick();
    chk("a_held_sx", int'(sx_a), 1279);
    #3 rst_a = 1'b0;
    tick();
    chk("a_restart_sx", int'(sx_a), -370);
    chk("a_restart_sy", int'(sy_a), -30);
    chk("a_restart_frame", int'(frame_a), 1);

    // 640x480 with active-low syncs
    #3 rst_b = 1'b0;
    tick();
    chk("b_rel_sx", int'(sx_b), -160);
    chk("b_rel_sy", int'(sy_b), -45);
    chk("b_rel_frame", int'(frame_b), 1);
    chk("b_rel_hs", int'(hs_b), 1);
    expect_val("b_line_count", 14);
    expect_val("b_line_period", 800);
    expect_val("b_hs_low_count", 14 * 96);
    expect_val("b_hs_low_first_x", -144);
    expect_val("b_hs_low_last_x", -49);
    expect_val("b_vs_low_count", 2 * 800);
    expect_val("b_vs_low_first_y", -35);
    expect_val("b_vs_low_last_y", -34);
    lines = 0; period = -1; hs_cnt = 0; hs_min = 32767; hs_max = -32768;
    vs_cnt = 0; vs_min = 32767; vs_max = -32768;
    for (int i = 0; i < 14 * 800; i++) begin
      if (line_b) begin
        lines++;
        if (lines == 2) period = i;
      end
      if (!hs_b) begin
        hs_cnt++;
        if (int'(sx_b) < hs_min) hs_min = int'(sx_b);
        if (int'(sx_b) > hs_max) hs_max = int'(sx_b);
      end
      if (!vs_b) begin
        vs_cnt++;
        if (int'(sy_b) < vs_min) vs_min = int'(sy_b);
        if (int'(sy_b) > vs_max) vs_max = int'(sy_b);
      end
      tick();
    end
    check_val(lines);
    check_val(period);
    check_val(hs_cnt);
    check_val(hs_min);
    check_val(hs_max);
    check_val(vs_cnt);
    check_val(vs_min);
    check_val(vs_max);

    // Tiny raster: 14-clock lines, 8-line frames, two full frames
    #3 rst_c = 1'b0;
    tick();
    expect_val("c_frame_count", 2);
    expect_val("c_frame_period", 112);
    expect_val("c_de_count", 2 * 32);
    expect_val("c_hs_count", 16 * 3);
    expect_val("c_vs_count", 2 * 2 * 14);
    expect_val("c_wraps_seen", 1);
    expect_val("c_end_de", 1);
    expect_val("c_wrap_sx", -6);
    expect_val("c_wrap_sy", -4);
    expect_val("c_wrap_frame", 1);
    expect_val("c_wrap_line", 1);
    expect_val("c_wrap_de", 0);
    frames = 0; fperiod = -1; de_cnt = 0; hs_cnt = 0; vs_cnt = 0; wraps = 0;
    w_sx = -99999; w_sy = -99999; w_fr = -1; w_ln = -1; w_de = -1; end_de = -1;
    prev_end = 1'b0;
    for (int i = 0; i < 224; i++) begin
      if (frame_c) begin
        frames++;
        if (frames == 2) fperiod = i;
      end
      if (de_c) de_cnt++;
      if (hs_c) hs_cnt++;
      if (vs_c) vs_cnt++;
      if (prev_end && wraps == 0) begin
        wraps++;
        w_sx = int'(sx_c); w_sy = int'(sy_c);
        w_fr = int'(frame_c); w_ln = int'(line_c); w_de = int'(de_c);
      end
      prev_end = (sx_c == 16'sd7) && (sy_c == 16'sd3);
      if (prev_end && end_de < 0) end_de = int'(de_c);
      tick();
    end
    check_val(frames);
    check_val(fperiod);
    check_val(de_cnt);
    check_val(hs_cnt);
    check_val(vs_cnt);
    check_val(wraps);
    check_val(end_de);
    check_val(w_sx);
    check_val(w_sy);
    check_val(w_fr);
    check_val(w_ln);
    check_val(w_de);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
